// File: rtl/pin_input_conditioner.sv
// pin_input_conditioner: synchronizes, glitch-filters and edge-detects the external pins.
// Optional macro PIN_LOOPBACK_EN adds pin_out/pin_dir so driven pins read back their own value.
module pin_input_conditioner #(
    parameter int WIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_cog,
    input  logic             res,
    input  logic [WIDTH-1:0] pin_raw,
    input  logic [WIDTH-1:0] filter_en,
`ifdef PIN_LOOPBACK_EN
    input  logic [WIDTH-1:0] pin_out,
    input  logic [WIDTH-1:0] pin_dir,
`endif
    output logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_change,
    output logic             change_any
);
    localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(FILTER_CYCLES - 1);
    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] s, q, accept;
    logic [CW-1:0] cnt [WIDTH];
    logic [CW-1:0] cnt_nx [WIDTH];
    assign s = sync[SYNC_STAGES-1];
    // A bypassed pin accepts any difference at once; a filtered one only at terminal count.
    always_comb begin
        accept = '0;
        cnt_nx = '{default: '0};
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != q[i]) && (!filter_en[i] || cnt[i] == TERM);
            cnt_nx[i] = (filter_en[i] && s[i] != q[i] && !accept[i]) ? cnt[i] + 1'b1 : '0;
        end
    end
    always_ff @(posedge clk_cog) begin
        if (res) begin
            sync <= '{default: RESET_VALUE};
            q <= RESET_VALUE;
            cnt <= '{default: '0};
            pin_change <= '0;
        end else begin
            sync[0] <= pin_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            q <= (q & ~accept) | (s & accept);
            cnt <= cnt_nx;
            pin_change <= accept;
        end
    end
`ifdef PIN_LOOPBACK_EN
    assign pin_in = (pin_dir & pin_out) | (~pin_dir & q);
`else
    assign pin_in = q;
`endif
    assign change_any = |pin_change;
endmodule
